// File: rtl/mac_pipeline_stage.sv
// Signed fixed-point multiply / multiply-add stage with saturation, LAT-deep valid/ready pipeline.
// Optional round-half-up before the shift when MAC_STAGE_ROUND_EN is defined.
module mac_pipeline_stage #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] coef,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] stage_out,
    output logic [WIDTH-1:0] x_out,
    output logic             overflow,
    output logic             overflow_sticky,
    input  logic             clr_sticky
);

    localparam int PW = 2*WIDTH + 1;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [PW-1:0]      w_prod_ext;
    logic signed [PW-1:0]      w_prod_rnd;
    logic signed [PW-1:0]      w_shift;
    logic signed [PW-1:0]      w_acc_ext;
    logic signed [PW-1:0]      w_sum;
    logic [WIDTH-1:0]          w_res;
    logic                      w_ovf;
    logic                      w_adv;

    logic                      r_valid [LAT];
    logic [WIDTH-1:0]          r_res   [LAT];
    logic [WIDTH-1:0]          r_x     [LAT];
    logic                      r_ovf   [LAT];
    logic                      r_sticky;

    assign w_prod     = $signed(x) * $signed(coef);
    assign w_prod_ext = {w_prod[2*WIDTH-1], w_prod};

`ifdef MAC_STAGE_ROUND_EN
    localparam int              RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW-1:0]   RND    = (FRAC > 0) ? ({{(PW-1){1'b0}}, 1'b1} << RND_SH) : '0;
    assign w_prod_rnd = w_prod_ext + $signed(RND);
`else
    assign w_prod_rnd = w_prod_ext;
`endif

    // Extra headroom bit keeps the shifted product plus addend from wrapping.
    assign w_shift   = w_prod_rnd >>> FRAC;
    assign w_acc_ext = {{(PW-WIDTH){acc_in[WIDTH-1]}}, acc_in};
    assign w_sum     = mode ? (w_shift + w_acc_ext) : w_shift;

    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        w_ovf = 1'b0;
        if (w_sum > SAT_MAX) begin
            w_res = {1'b0, {(WIDTH-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (w_sum < SAT_MIN) begin
            w_res = {1'b1, {(WIDTH-1){1'b0}}};
            w_ovf = 1'b1;
        end
    end

    // Global stall: every slot advances together, bubbles included.
    assign w_adv    = !r_valid[LAT-1] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_valid[i] <= 1'b0;
                r_res[i]   <= '0;
                r_x[i]     <= '0;
                r_ovf[i]   <= 1'b0;
            end
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            r_res[0]   <= w_res;
            r_x[0]     <= x;
            r_ovf[0]   <= w_ovf;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_res[i]   <= r_res[i-1];
                r_x[i]     <= r_x[i-1];
                r_ovf[i]   <= r_ovf[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sticky <= 1'b0;
        end else if (r_valid[LAT-1] && out_ready && r_ovf[LAT-1]) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid       = r_valid[LAT-1];
    assign stage_out       = r_res[LAT-1];
    assign x_out           = r_x[LAT-1];
    assign overflow        = r_ovf[LAT-1];
    assign overflow_sticky = r_sticky;

endmodule

// File: doc/mac_pipeline_stage.md
Name: mac_pipeline_stage

Overview:
- Parametrised successor of the first Taylor-series pipeline stage.
- Computes sat((x * coef) >> FRAC), or, in multiply-add mode, sat(((x * coef) >> FRAC) + acc_in).
- Signed fixed point throughout, with a configurable register depth and valid/ready flow control.
- Passes x through alongside the result, so identical stages can be chained to form term_k = term_(k-1) * x * (1/k) plus a running sum.
- Provides a per-result overflow flag and a sticky overflow flag.

Parameters:
- WIDTH, 32: data width of x, coef, acc_in and stage_out (two's complement).
- FRAC, 16: number of fractional bits in the Q format; legal range 0..WIDTH-1.
- LAT, 2: pipeline register depth; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept an input beat.
- x  in  WIDTH  signed operand; also passed through to x_out.
- coef  in  WIDTH  signed coefficient (1/n from LUT).
- acc_in  in  WIDTH  signed addend, used only when mode=1.
- mode  in  1  0 = multiply only, 1 = multiply-add; sampled with the input beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- stage_out  out  WIDTH  saturated result.
- x_out  out  WIDTH  x of the same beat, delayed to align with stage_out.
- overflow  out  1  saturation occurred for the current output beat.
- overflow_sticky  out  1  at least one saturated beat has been delivered since reset or the last clear.
- clr_sticky  in  1  synchronous clear of overflow_sticky.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pipeline valid bits, stage_out, x_out, overflow and overflow_sticky go to 0.
  - In-flight beats are discarded.
  - in_ready=1 from the first clock edge after release.
- Arithmetic, performed combinationally on the accepted beat before the first register:
  - p = x*coef as a full 2*WIDTH signed product.
  - q = p >>> FRAC (arithmetic shift, truncation toward minus infinity), held at 2*WIDTH+1 bits.
  - If mode=1, q = q + sign-extended acc_in.
  - If q > 2^(WIDTH-1)-1, result = 0x7FF..F and overflow=1.
  - If q < -2^(WIDTH-1), result = 0x800..0 and overflow=1.
  - Otherwise result = q[WIDTH-1:0] and overflow=0.
  - Overflow is detected on the true signed range, never on unsigned comparisons.
- Pipeline:
  - LAT register slots, each holding {valid, result, x, overflow}.
  - Slot LAT-1 drives out_valid, stage_out, x_out and overflow.
  - adv = !out_valid || out_ready; all slots shift together when adv=1 and hold when adv=0. This is a global stall: bubbles are not compressed.
  - in_ready = adv, purely combinational from out_valid and out_ready.
  - Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
  - Latency is exactly LAT cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 beat/cycle. Beats leave in acceptance order; none are dropped or duplicated.
  - While stalled, stage_out, x_out and overflow are held stable.
  - A slot receiving no beat gets valid=0. Data registers may hold stale values, but out_valid=0 qualifies them.
- Sticky flag:
  - Set on an output transfer whose overflow=1.
  - Cleared when clr_sticky=1.
  - If set and clear occur in the same cycle, set wins.
- Edge cases:
  - FRAC=0 means no shift.
  - coef=0 gives result 0 (or acc_in in mode 1) with no overflow.
  - x = coef = most-negative value: the product is positive and overflows; result saturates to the maximum.

Optional Feature:
- Macro: MAC_STAGE_ROUND_EN.
- Defined: add 2^(FRAC-1) to p before the shift (round half up). The addition is done at 2*WIDTH+1 bits so it cannot wrap. Has no effect when FRAC=0.
- Undefined: truncation as described in Behaviour. Ports, latency and handshake are identical in both builds.

Test Plan (WIDTH=32, FRAC=16, LAT=2 unless noted):
- Basic multiply: x=0x00020000, coef=0x00008000, mode=0, out_ready=1.
  - out_valid exactly 2 cycles after acceptance.
  - stage_out=0x00010000, x_out=0x00020000, overflow=0, sticky=0.
- Positive saturation: x=0x7FFF0000, coef=0x00020000.
  - stage_out=0x7FFFFFFF, overflow=1.
  - sticky=1 after the transfer; clr_sticky pulse returns it to 0.
- Negative saturation: x=0x80000000, coef=0x00020000.
  - stage_out=0x80000000, overflow=1.
- Multiply-add, mode=1, x=0x00010000, coef=0x00030000:
  - acc_in=0x00010000 gives stage_out=0x00040000, overflow=0.
  - acc_in=0x7FFF0000 gives 0x7FFFFFFF, overflow=1.
- Backpressure: out_ready=0 for 5 cycles while beats A, B, C are offered back-to-back.
  - A and B are accepted; in_ready=0 from the third cycle on.
  - stage_out holds A stable.
  - After out_ready=1, the outputs are A, B, C in order with no loss.
- Reset mid-flight and rounding:
  - Reset asserted with 2 beats in flight: out_valid=0 and sticky=0 immediately; no stale beat appears after release.
  - x=0x00000001, coef=0x00008000: stage_out=0 without MAC_STAGE_ROUND_EN, 1 with it.
